// File: rtl/scene_render.sv
// Rex Runner raster stage: snapshots the scene on gpu_en and streams one monochrome frame
// over a valid/ready pixel interface. Optional macro SCENE_OVER_INVERT_EN inverts OVER frames.
module scene_render #(
    parameter int unsigned SCR_W    = 128,
    parameter int unsigned SCR_H    = 64,
    parameter int unsigned GROUND_Y = 56,
    parameter int unsigned DINO_X   = 8,
    parameter int unsigned DINO_W   = 12,
    parameter int unsigned DINO_H   = 12,
    parameter int unsigned OBS_W    = 6,
    parameter int unsigned OBS_H    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gpu_en,
    input  logic [6:0] dino_y,
    input  logic [8:0] obstacle_x,
    input  logic [1:0] state,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [8:0] pix_x,
    output logic [6:0] pix_y,
    output logic       pix_val,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [8:0] XLast = 9'(SCR_W - 1);
    localparam logic [6:0] YLast = 7'(SCR_H - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_e;

    fsm_e       r_st;
    logic [6:0] r_a_dino_y, r_p_dino_y;
    logic [8:0] r_a_obs_x, r_p_obs_x;
    logic [1:0] r_a_state, r_p_state;
    logic       r_pend;
    logic       r_pix_valid, r_pix_val, r_busy, r_frame_done;
    logic [8:0] r_pix_x;
    logic [6:0] r_pix_y;

    logic       w_xwrap, w_last;
    logic [8:0] w_nx;
    logic [6:0] w_ny;
    logic       w_val_nxt, w_val_in, w_val_pend;

    function automatic logic pix_fn(input logic [8:0] x, input logic [6:0] y,
                                    input logic [6:0] dy, input logic [8:0] ox,
                                    input logic [1:0] st);
        int unsigned ux, uy, udy, uox, top;
        logic        on;
        ux  = 32'(x);
        uy  = 32'(y);
        udy = 32'(dy);
        uox = 32'(ox);
        top = (udy > GROUND_Y - DINO_H) ? 0 : GROUND_Y - DINO_H - udy;
        on  = (uy == GROUND_Y);
        if (ux >= DINO_X && ux <= DINO_X + DINO_W - 1 && uy >= top && uy <= top + DINO_H - 1)
            on = 1'b1;
        // Wide compare: obstacles hanging past the right edge never wrap onto column 0.
        if (st != 2'd0 && ux >= uox && ux <= uox + OBS_W - 1 &&
            uy >= GROUND_Y - OBS_H && uy <= GROUND_Y - 1)
            on = 1'b1;
`ifdef SCENE_OVER_INVERT_EN
        if (st[1]) on = ~on;
`endif
        return on;
    endfunction

    assign w_xwrap    = (r_pix_x == XLast);
    assign w_last     = w_xwrap && (r_pix_y == YLast);
    assign w_nx       = w_xwrap ? 9'd0 : r_pix_x + 9'd1;
    assign w_ny       = w_xwrap ? r_pix_y + 7'd1 : r_pix_y;
    assign w_val_nxt  = pix_fn(w_nx, w_ny, r_a_dino_y, r_a_obs_x, r_a_state);
    assign w_val_in   = pix_fn(9'd0, 7'd0, dino_y, obstacle_x, state);
    assign w_val_pend = pix_fn(9'd0, 7'd0, r_p_dino_y, r_p_obs_x, r_p_state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st         <= IDLE;
            r_a_dino_y   <= '0;
            r_a_obs_x    <= '0;
            r_a_state    <= '0;
            r_p_dino_y   <= '0;
            r_p_obs_x    <= '0;
            r_p_state    <= '0;
            r_pend       <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_val    <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_st)
                IDLE: begin
                    if (gpu_en) begin
                        r_a_dino_y  <= dino_y;
                        r_a_obs_x   <= obstacle_x;
                        r_a_state   <= state;
                        r_st        <= DRAW;
                        r_pix_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pix_x     <= '0;
                        r_pix_y     <= '0;
                        r_pix_val   <= w_val_in;
                    end
                end
                DRAW: begin
                    if (gpu_en) begin
                        r_p_dino_y <= dino_y;
                        r_p_obs_x  <= obstacle_x;
                        r_p_state  <= state;
                        r_pend     <= 1'b1;
                    end
                    if (pix_ready) begin
                        if (w_last) begin
                            r_st         <= DONE;
                            r_pix_valid  <= 1'b0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_pix_x      <= '0;
                            r_pix_y      <= '0;
                            r_pix_val    <= 1'b0;
                        end else begin
                            r_pix_x   <= w_nx;
                            r_pix_y   <= w_ny;
                            r_pix_val <= w_val_nxt;
                        end
                    end
                end
                DONE: begin
                    if (gpu_en || r_pend) begin
                        // A request in this very cycle is the newest one and wins.
                        r_st        <= DRAW;
                        r_pend      <= 1'b0;
                        r_pix_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pix_x     <= '0;
                        r_pix_y     <= '0;
                        if (gpu_en) begin
                            r_a_dino_y <= dino_y;
                            r_a_obs_x  <= obstacle_x;
                            r_a_state  <= state;
                            r_pix_val  <= w_val_in;
                        end else begin
                            r_a_dino_y <= r_p_dino_y;
                            r_a_obs_x  <= r_p_obs_x;
                            r_a_state  <= r_p_state;
                            r_pix_val  <= w_val_pend;
                        end
                    end else begin
                        r_st <= IDLE;
                    end
                end
                default: r_st <= IDLE;
            endcase
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_val    = r_pix_val;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scene_render.sv
// Directed self-checking bench for scene_render; frames are captured into an image array
// and probed at hand-computed pixels.
module tb_scene_render;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gpu_en = 1'b0;
    logic [6:0] dino_y = '0;
    logic [8:0] obstacle_x = '0;
    logic [1:0] state = '0;
    logic       pix_ready = 1'b1;
    logic       pix_valid, pix_val, busy, frame_done;
    logic [8:0] pix_x;
    logic [6:0] pix_y;

    int n_checks = 0;
    int n_fail   = 0;
    logic img [0:63][0:127];

    scene_render dut (
        .clk        (clk),
        .rst        (rst),
        .gpu_en     (gpu_en),
        .dino_y     (dino_y),
        .obstacle_x (obstacle_x),
        .state      (state),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_val    (pix_val),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pulse gpu_en for one cycle; returns at the negedge where pixel (0,0) should be shown.
    task automatic start_frame(input logic [6:0] dy, input logic [8:0] ox, input logic [1:0] st);
        @(negedge clk);
        dino_y = dy; obstacle_x = ox; state = st; gpu_en = 1'b1;
        @(negedge clk);
        gpu_en = 1'b0;
    endtask

    // Record accepted beats from the current negedge until frame_done (bounded).
    task automatic capture(output int beats, output int dones, output int order_err,
                           output logic fd_busy, output logic fd_valid);
        int ex, ey;
        beats = 0; dones = 0; order_err = 0; ex = 0; ey = 0;
        fd_busy = 1'bx; fd_valid = 1'bx;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (pix_valid && pix_ready) begin
                if (32'(pix_x) != ex || 32'(pix_y) != ey) order_err++;
                if (pix_x < 9'd128 && pix_y < 7'd64) img[pix_y[5:0]][pix_x[6:0]] = pix_val;
                beats++;
                if (ex == 127) begin ex = 0; ey++; end else ex++;
            end
            if (frame_done) begin
                dones++; fd_busy = busy; fd_valid = pix_valid;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_val, busy, frame_done} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b x=%0d y=%0d val=%b busy=%b fd=%b want all 0",
                     pix_valid, pix_x, pix_y, pix_val, busy, frame_done);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got v=%b busy=%b want 0 0", pix_valid, busy);
        end
    endtask

    task automatic test_basic_frame;
        int beats, dones, oerr, ones;
        logic fb, fv;
        int px[9] = '{8, 8, 19, 20, 60, 65, 66, 60, 0};
        int py[9] = '{44, 43, 55, 55, 46, 55, 55, 45, 0};
        logic pe[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        start_frame(7'd0, 9'd60, 2'd1);
        n_checks++;
        if (pix_valid !== 1'b1 || busy !== 1'b1 || pix_x !== 9'd0 || pix_y !== 7'd0) begin
            n_fail++;
            $display("FAIL first_beat: got v=%b busy=%b (%0d,%0d) want 1 1 (0,0)",
                     pix_valid, busy, pix_x, pix_y);
        end
        capture(beats, dones, oerr, fb, fv);
        n_checks++;
        if (beats !== 8192 || dones !== 1 || oerr !== 0) begin
            n_fail++;
            $display("FAIL basic_count: got beats=%0d dones=%0d order_err=%0d want 8192 1 0",
                     beats, dones, oerr);
        end
        n_checks++;
        if (fb !== 1'b0 || fv !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle: got busy=%b valid=%b want 0 0", fb, fv);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got fd=%b valid=%b want 0 0", frame_done, pix_valid);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (img[py[i]][px[i]] !== pe[i]) begin
                n_fail++;
                $display("FAIL basic_px(%0d,%0d): got %b want %b", px[i], py[i],
                         img[py[i]][px[i]], pe[i]);
            end
        end
        ones = 0;
        for (int x = 0; x < 128; x++) if (img[56][x] === 1'b1) ones++;
        n_checks++;
        if (ones !== 128) begin
            n_fail++;
            $display("FAIL ground_row: got %0d lit want 128", ones);
        end
    endtask

    task automatic test_jump_ready;
        int beats, dones, oerr;
        logic fb, fv;
        start_frame(7'd36, 9'd60, 2'd0);
        capture(beats, dones, oerr, fb, fv);
        for (int y = 0; y < 56; y++) begin
            n_checks++;
            if (img[y][8] !== ((y >= 8 && y <= 19) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL jump_col8_y%0d: got %b want %b", y, img[y][8], y >= 8 && y <= 19);
            end
        end
        n_checks++;
        if (img[50][60] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_no_obstacle: got %b want 0", img[50][60]);
        end
    endtask

    task automatic test_edge;
        int beats, dones, oerr, bad;
        logic fb, fv;
        start_frame(7'd0, 9'd125, 2'd1);
        capture(beats, dones, oerr, fb, fv);
        for (int y = 46; y <= 55; y++) begin
            for (int x = 125; x < 128; x++) begin
                n_checks++;
                if (img[y][x] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL edge_on(%0d,%0d): got %b want 1", x, y, img[y][x]);
                end
            end
            for (int x = 0; x < 3; x++) begin
                n_checks++;
                if (img[y][x] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL edge_wrap(%0d,%0d): got %b want 0", x, y, img[y][x]);
                end
            end
        end
        start_frame(7'd0, 9'd510, 2'd1);
        capture(beats, dones, oerr, fb, fv);
        bad = 0;
        for (int y = 46; y <= 55; y++)
            for (int x = 20; x < 128; x++) if (img[y][x] !== 1'b0) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL offscreen_obstacle: got %0d lit want 0", bad);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        cyc = 0;
        start_frame(7'd0, 9'd60, 2'd1);
        while (!(pix_x == 9'd3 && pix_y == 7'd0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (pix_valid !== 1'b1 || pix_x !== 9'd3 || pix_y !== 7'd0 || pix_val !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: got v=%b (%0d,%0d) val=%b want 1 (3,0) 0",
                         i, pix_valid, pix_x, pix_y, pix_val);
            end
        end
        pix_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b1 || pix_x !== 9'd4 || pix_y !== 7'd0) begin
            n_fail++;
            $display("FAIL after_stall: got v=%b (%0d,%0d) want 1 (4,0)", pix_valid, pix_x, pix_y);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_coalesce;
        int beats, dones, oerr, cyc;
        logic fb, fv;
        start_frame(7'd0, 9'd60, 2'd1);
        repeat (100) @(negedge clk);
        dino_y = 7'd15; gpu_en = 1'b1;
        @(negedge clk);
        gpu_en = 1'b0;
        repeat (100) @(negedge clk);
        dino_y = 7'd27; gpu_en = 1'b1;
        @(negedge clk);
        gpu_en = 1'b0;
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL coalesce_first_done: got %b want 1", frame_done);
        end
        @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b1 || busy !== 1'b1 || pix_x !== 9'd0 || pix_y !== 7'd0) begin
            n_fail++;
            $display("FAIL back_to_back: got v=%b busy=%b (%0d,%0d) want 1 1 (0,0)",
                     pix_valid, busy, pix_x, pix_y);
        end
        capture(beats, dones, oerr, fb, fv);
        n_checks++;
        if (beats !== 8192 || dones !== 1 || oerr !== 0) begin
            n_fail++;
            $display("FAIL coalesce_count: got beats=%0d dones=%0d order_err=%0d want 8192 1 0",
                     beats, dones, oerr);
        end
        n_checks++;
        if (img[16][8] !== 1'b0 || img[17][8] !== 1'b1 || img[28][8] !== 1'b1 ||
            img[29][8] !== 1'b0) begin
            n_fail++;
            $display("FAIL coalesce_top: got rows16..17=%b%b 28..29=%b%b want 0110",
                     img[16][8], img[17][8], img[28][8], img[29][8]);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_extra_frame: got v=%b busy=%b want 0 0", pix_valid, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int seen;
        start_frame(7'd0, 9'd60, 2'd1);
        repeat (500) @(negedge clk);
        gpu_en = 1'b1;
        @(negedge clk);
        gpu_en = 1'b0;
        repeat (499) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_val, busy, frame_done} !== 20'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b x=%0d y=%0d val=%b busy=%b fd=%b want all 0",
                     pix_valid, pix_x, pix_y, pix_val, busy, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pix_valid || frame_done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL after_abort: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_over_frame;
        int beats, dones, oerr, ones;
        logic fb, fv;
        logic exp00, exp_row;
`ifdef SCENE_OVER_INVERT_EN
        exp00 = 1'b1; exp_row = 1'b0;
`else
        exp00 = 1'b0; exp_row = 1'b1;
`endif
        start_frame(7'd0, 9'd60, 2'd2);
        capture(beats, dones, oerr, fb, fv);
        n_checks++;
        if (img[0][0] !== exp00) begin
            n_fail++;
            $display("FAIL over_px00: got %b want %b", img[0][0], exp00);
        end
        ones = 0;
        for (int x = 0; x < 128; x++) if (img[56][x] === exp_row) ones++;
        n_checks++;
        if (ones !== 128) begin
            n_fail++;
            $display("FAIL over_row56: got %0d matching want 128", ones);
        end
        n_checks++;
        if (img[46][60] !== exp_row) begin
            n_fail++;
            $display("FAIL over_obstacle: got %b want %b", img[46][60], exp_row);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_jump_ready();
        test_edge();
        test_backpressure();
        test_coalesce();
        test_reset_mid_frame();
        test_over_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scene_render.md
# scene_render

Downstream rendering stage for the Rex Runner game core. It consumes the scene snapshot the game centre publishes with `gpu_en`: dino height offset, obstacle x position and game state. It then raster-scans one full monochrome frame, emitting one pixel per valid/ready beat toward the display/framebuffer driver. One frame is drawn per `gpu_en` request; requests that arrive mid-frame are coalesced, and the latest one wins.

## Interface
- `SCR_W`, 128, screen width in pixels
- `SCR_H`, 64, screen height in pixels
- `GROUND_Y`, 56, row of the ground line
- `DINO_X`, 8, left column of the dino box
- `DINO_W` / `DINO_H`, 12 / 12, dino box size
- `OBS_W` / `OBS_H`, 6 / 10, obstacle box size
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `gpu_en`  in  1  frame request; a 1-cycle pulse from the game centre
- `dino_y`  in  7  dino height above ground (0..36)
- `obstacle_x`  in  9  obstacle left column, screen coordinates
- `state`  in  2  0 = READY, 1 = RUN, 2 = OVER, 3 = treated as OVER
- `pix_valid`  out  1  pixel beat valid
- `pix_ready`  in  1  downstream accepts the beat
- `pix_x`  out  9  pixel column
- `pix_y`  out  7  pixel row
- `pix_val`  out  1  1 = pixel on
- `busy`  out  1  frame in progress
- `frame_done`  out  1  1-cycle pulse after the last pixel is accepted

## Operation
- FSM has three states: IDLE, DRAW, DONE.
  - IDLE → DRAW when `gpu_en` is high.
  - DRAW → DONE when pixel (SCR_W-1, SCR_H-1) is accepted.
  - DONE → DRAW if a request is pending, else DONE → IDLE.
- Snapshot registers (`dino_y`, `obstacle_x`, `state`) load on every sampled `gpu_en`.
  - In IDLE they feed the new frame directly.
  - In DRAW or DONE they go into a pending snapshot and the pending flag is set. A later request overwrites the pending snapshot.
- A pending request moves into the active snapshot on the DONE → DRAW transition, and the pending flag clears.
- The active snapshot is frozen for the whole frame.
- Scan order is x fastest, 0..SCR_W-1, then y, 0..SCR_H-1.
  - A beat is accepted when `pix_valid` and `pix_ready` are both high; acceptance advances the counters.
  - x wraps to 0 and y increments at SCR_W-1.
- `pix_val` is the OR of three terms:
  - Ground: `pix_y` == GROUND_Y.
  - Dino:
    - `pix_x` in [DINO_X, DINO_X+DINO_W-1].
    - `pix_y` in [top, top+DINO_H-1], where top = GROUND_Y-DINO_H-`dino_y`.
    - If `dino_y` > GROUND_Y-DINO_H, top clamps to 0.
  - Obstacle: only when state != READY.
    - `pix_x` in [`obstacle_x`, `obstacle_x`+OBS_W-1]. Compare in 10 bits so there is no wrap; columns ≥ SCR_W are simply never scanned.
    - `pix_y` in [GROUND_Y-OBS_H, GROUND_Y-1].
- The pixel function is registered alongside `pix_x`/`pix_y`, so all three output fields always belong to the same beat.

## Timing
- Reset values, applied asynchronously and held while `rst` = 0:
  - FSM = IDLE.
  - `pix_valid`, `pix_x`, `pix_y`, `pix_val`, `busy`, `frame_done` = 0.
  - Pending flag and both snapshots = 0.
- `gpu_en` sampled in IDLE at edge N:
  - At edge N+1, `busy` = 1, `pix_valid` = 1 and pixel (0,0) is presented.
- With `pix_ready` tied high:
  - One pixel per cycle; DRAW lasts SCR_W*SCR_H = 8192 cycles.
  - `frame_done` is high for exactly 1 cycle, in DONE. `busy` = 0 and `pix_valid` = 0 in that cycle.
- Backpressure: while `pix_valid` && !`pix_ready`, `pix_x`, `pix_y` and `pix_val` hold stable and `pix_valid` stays 1.
- Back-to-back frames: DONE → DRAW, and pixel (0,0) of the next frame appears 1 cycle after `frame_done`.
- `gpu_en` in the DONE cycle counts as pending.
- Reset mid-frame aborts immediately. There is no `frame_done` and the pending request is discarded.

## Configuration
- `SCENE_OVER_INVERT_EN` defined: when the active state is OVER or 3, every `pix_val` is inverted for the whole frame.
- `SCENE_OVER_INVERT_EN` undefined: the OVER frame renders exactly like RUN.

## Test plan
- Basic frame:
  - Stimulus: reset, then `gpu_en` with `dino_y`=0, `obstacle_x`=60, state=1, `pix_ready`=1.
  - Required: exactly 8192 beats and one `frame_done`.
  - Required pixels: (8,44)=1, (8,43)=0, (19,55)=1, (20,55)=0, (60,46)=1, (65,55)=1, (66,55)=0, (60,45)=0, every pixel of row 56 = 1.
- Jump and clamp:
  - `dino_y`=36 → dino rows 8..19 only.
  - READY state with `obstacle_x`=60 → pixel (60,50)=0.
- Edge and off-screen:
  - `obstacle_x`=125 → columns 125..127 on in rows 46..55, columns 0..2 off.
  - `obstacle_x`=510 → no obstacle pixels.
- Backpressure: `pix_ready`=0 for 5 cycles while (3,0) is presented → outputs unchanged; the next accepted beat is (4,0).
- Coalescing:
  - Two `gpu_en` mid-frame, with `dino_y`=15 then 27 → exactly one extra frame, with dino top at row 17.
  - Its (0,0) appears 1 cycle after `frame_done`.
- Reset mid-frame and macro:
  - Reset asserted at beat 1000 → all outputs 0, no further beats and no `frame_done`.
  - With `SCENE_OVER_INVERT_EN` and state=2 → (0,0)=1 and row 56 = 0.
